// File: rtl/axi_stream_hdr_pkg.sv
// axi_stream_hdr_pkg: shared state type and byte-mask helpers for the header strip path
package axi_stream_hdr_pkg;

   localparam int MAX_BYTE_WD = 128;

   typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_e;

   function automatic logic [MAX_BYTE_WD-1:0] keep_from_cnt(input int cnt, input int bytes);
      logic [MAX_BYTE_WD-1:0] m;
      for (int i = 0; i < MAX_BYTE_WD; i++) m[i] = (i < bytes) && (i >= bytes - cnt);
      return m;
   endfunction

   function automatic int keep_popcount(input logic [MAX_BYTE_WD-1:0] keep);
      return $countones(keep);
   endfunction

   function automatic logic [MAX_BYTE_WD-1:0] keep_right(input int cnt);
      logic [MAX_BYTE_WD-1:0] m;
      for (int i = 0; i < MAX_BYTE_WD; i++) m[i] = i < cnt;
      return m;
   endfunction

endpackage

// File: rtl/axi_stream_byte_realign.sv
// axi_stream_byte_realign: splices held bytes with the current beat and derives header/last-beat keeps
module axi_stream_byte_realign
   import axi_stream_hdr_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic [DATA_WD-1:0]      held_i,
   input  logic [DATA_WD-1:0]      data_i,
   input  logic [DATA_BYTE_WD-1:0] keep_i,
   input  logic [BYTE_CNT_WD:0]    n_i,
   input  logic                    first_i,
   output logic [DATA_WD-1:0]      beat_o,
   output logic [DATA_WD-1:0]      beat_last_o,
   output logic [DATA_WD-1:0]      hold_o,
   output logic [DATA_WD-1:0]      hold_last_o,
   output logic [DATA_WD-1:0]      hdr_data_o,
   output logic [DATA_BYTE_WD-1:0] last_keep_o,
   output logic [DATA_BYTE_WD-1:0] flush_keep_o,
   output logic [DATA_BYTE_WD-1:0] hdr_keep_o,
`ifdef STRIP_HDR_ERR_EN
   output logic                    short_o,
`endif
   output logic                    more_o
);

   int n, h, k;

   // held bytes sit left-aligned, so a body beat is held | (beat >> H bytes); out-of-range masks clamp to 0/all-ones
   always_comb begin
      n = int'(n_i);
      h = DATA_BYTE_WD - n;
      k = keep_popcount(MAX_BYTE_WD'(keep_i));
      hold_o = data_i << (8 * n);
      beat_o = first_i ? hold_o : (held_i | (data_i >> (8 * h)));
      last_keep_o = DATA_BYTE_WD'(keep_from_cnt(first_i ? k - n : h + k, DATA_BYTE_WD));
      flush_keep_o = DATA_BYTE_WD'(keep_from_cnt(k - n, DATA_BYTE_WD));
      hdr_keep_o = DATA_BYTE_WD'(keep_right(n)) & (keep_i >> h);
      more_o = k > n;
`ifdef STRIP_HDR_ERR_EN
      short_o = k < n;
`endif
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         beat_last_o[8*i +: 8] = beat_o[8*i +: 8] & {8{last_keep_o[i]}};
         hold_last_o[8*i +: 8] = hold_o[8*i +: 8] & {8{flush_keep_o[i]}};
         hdr_data_o[8*i +: 8] = data_i[8*(i+h) +: 8] & {8{hdr_keep_o[i]}};
      end
   end

endmodule

// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: strips an N-byte header off each AXI-Stream packet; STRIP_HDR_ERR_EN adds err_short
module axi_stream_strip_header
   import axi_stream_hdr_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_strip,
   input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
   output logic                    ready_strip,
   output logic                    valid_header,
   output logic [DATA_WD-1:0]      data_header,
   output logic [DATA_BYTE_WD-1:0] keep_header,
`ifdef STRIP_HDR_ERR_EN
   output logic                    err_short,
`endif
   input  logic                    ready_header
);

   state_e                  state_q, state_d;
   logic [BYTE_CNT_WD:0]    n_q, n_d;
   logic [DATA_WD-1:0]      held_q, held_d;
   logic [DATA_BYTE_WD-1:0] flush_keep_q, flush_keep_d;
   logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
   logic [DATA_WD-1:0]      data_out_q, data_out_d;
   logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
   logic                    valid_header_q, valid_header_d;
   logic [DATA_WD-1:0]      data_header_q, data_header_d;
   logic [DATA_BYTE_WD-1:0] keep_header_q, keep_header_d;
   logic [DATA_WD-1:0]      beat, beat_last, hold, hold_last, hdr_data;
   logic [DATA_BYTE_WD-1:0] last_keep, flush_keep, hdr_keep;
   logic                    more, out_free, accept;
`ifdef STRIP_HDR_ERR_EN
   logic                    short, err_q, err_d;
`endif

   axi_stream_byte_realign #(
      .DATA_WD     (DATA_WD),
      .DATA_BYTE_WD(DATA_BYTE_WD),
      .BYTE_CNT_WD (BYTE_CNT_WD)
   ) u_realign (
      .held_i      (held_q),
      .data_i      (data_in),
      .keep_i      (keep_in),
      .n_i         (n_q),
      .first_i     (state_q == HDR),
      .beat_o      (beat),
      .beat_last_o (beat_last),
      .hold_o      (hold),
      .hold_last_o (hold_last),
      .hdr_data_o  (hdr_data),
      .last_keep_o (last_keep),
      .flush_keep_o(flush_keep),
      .hdr_keep_o  (hdr_keep),
`ifdef STRIP_HDR_ERR_EN
      .short_o     (short),
`endif
      .more_o      (more)
   );

   assign out_free     = !valid_out_q || ready_out;
   assign ready_in     = state_q == HDR ? !valid_header_q && out_free : state_q == BODY && out_free;
   assign ready_strip  = state_q == IDLE;
   assign accept       = valid_in && ready_in;
   assign valid_out    = valid_out_q;
   assign data_out     = data_out_q;
   assign keep_out     = keep_out_q;
   assign last_out     = last_out_q;
   assign valid_header = valid_header_q;
   assign data_header  = data_header_q;
   assign keep_header  = keep_header_q;
`ifdef STRIP_HDR_ERR_EN
   assign err_short    = err_q;
`endif

   // next-state: descriptor latch, header capture, payload re-alignment and trailing flush
   always_comb begin
      state_d = state_q;
      n_d = n_q;
      held_d = held_q;
      flush_keep_d = flush_keep_q;
      valid_out_d = valid_out_q && !ready_out;
      data_out_d = data_out_q;
      keep_out_d = keep_out_q;
      last_out_d = last_out_q;
      valid_header_d = valid_header_q && !ready_header;
      data_header_d = data_header_q;
      keep_header_d = keep_header_q;
`ifdef STRIP_HDR_ERR_EN
      err_d = 1'b0;
`endif
      if (state_q == IDLE && valid_strip) begin
         n_d = {1'b0, byte_strip_cnt} + 1'b1;
         state_d = HDR;
      end
      if (state_q == HDR && accept) begin
         valid_header_d = 1'b1;
         data_header_d = hdr_data;
         keep_header_d = hdr_keep;
         held_d = hold;
`ifdef STRIP_HDR_ERR_EN
         err_d = last_in && short;
`endif
         state_d = last_in ? IDLE : BODY;
         if (last_in && more) begin
            valid_out_d = 1'b1;
            data_out_d = beat_last;
            keep_out_d = last_keep;
            last_out_d = 1'b1;
         end
      end
      if (state_q == BODY && accept) begin
         valid_out_d = 1'b1;
         held_d = last_in && more ? hold_last : hold;
         flush_keep_d = flush_keep;
         data_out_d = last_in && !more ? beat_last : beat;
         keep_out_d = last_in && !more ? last_keep : '1;
         last_out_d = last_in && !more;
         state_d = !last_in ? BODY : more ? FLUSH : IDLE;
      end
      if (state_q == FLUSH && out_free) begin
         valid_out_d = 1'b1;
         data_out_d = held_q;
         keep_out_d = flush_keep_q;
         last_out_d = 1'b1;
         state_d = IDLE;
      end
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q <= '0;
         held_q <= '0;
         flush_keep_q <= '0;
         valid_out_q <= 1'b0;
         data_out_q <= '0;
         keep_out_q <= '0;
         last_out_q <= 1'b0;
         valid_header_q <= 1'b0;
         data_header_q <= '0;
         keep_header_q <= '0;
`ifdef STRIP_HDR_ERR_EN
         err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         n_q <= n_d;
         held_q <= held_d;
         flush_keep_q <= flush_keep_d;
         valid_out_q <= valid_out_d;
         data_out_q <= data_out_d;
         keep_out_q <= keep_out_d;
         last_out_q <= last_out_d;
         valid_header_q <= valid_header_d;
         data_header_q <= data_header_d;
         keep_header_q <= keep_header_d;
`ifdef STRIP_HDR_ERR_EN
         err_q <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb_axi_stream_strip_header: directed vectors for the header stripper, DATA_WD=32
module tb_axi_stream_strip_header;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in, last_in, ready_in, valid_out, last_out, ready_out;
   logic [31:0] data_in, data_out, data_header;
   logic [3:0]  keep_in, keep_out, keep_header;
   logic        valid_strip, ready_strip, valid_header, ready_header;
   logic [1:0]  byte_strip_cnt;
`ifdef STRIP_HDR_ERR_EN
   logic        err_short;
`endif
   logic [36:0] out_q[$];
   logic [35:0] hdr_q[$];
   int          err_cnt = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   axi_stream_strip_header #(.DATA_WD(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid_in      (valid_in),
      .data_in       (data_in),
      .keep_in       (keep_in),
      .last_in       (last_in),
      .ready_in      (ready_in),
      .valid_out     (valid_out),
      .data_out      (data_out),
      .keep_out      (keep_out),
      .last_out      (last_out),
      .ready_out     (ready_out),
      .valid_strip   (valid_strip),
      .byte_strip_cnt(byte_strip_cnt),
      .ready_strip   (ready_strip),
      .valid_header  (valid_header),
      .data_header   (data_header),
      .keep_header   (keep_header),
`ifdef STRIP_HDR_ERR_EN
      .err_short     (err_short),
`endif
      .ready_header  (ready_header)
   );

   // record every completed output/header handshake and err pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_out && ready_out) out_q.push_back({last_out, keep_out, data_out});
         if (valid_header && ready_header) hdr_q.push_back({keep_header, data_header});
`ifdef STRIP_HDR_ERR_EN
         if (err_short) err_cnt++;
`endif
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic exp_out(input string tag, input logic [36:0] e);
      chk({tag, "_present"}, 64'(out_q.size() != 0), 64'd1);
      if (out_q.size() != 0) chk(tag, 64'(out_q.pop_front()), 64'(e));
   endtask

   task automatic exp_hdr(input string tag, input logic [35:0] e, input logic [35:0] m);
      logic [35:0] g;
      chk({tag, "_present"}, 64'(hdr_q.size() != 0), 64'd1);
      if (hdr_q.size() != 0) begin
         g = hdr_q.pop_front();
         chk(tag, 64'(g & m), 64'(e & m));
      end
   endtask

   task automatic exp_empty(input string tag);
      chk({tag, "_out_extra"}, 64'(out_q.size()), 64'd0);
      chk({tag, "_hdr_extra"}, 64'(hdr_q.size()), 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_desc(input logic [1:0] cnt);
      int t = 0;
      valid_strip = 1'b1;
      byte_strip_cnt = cnt;
      @(negedge clk);
      while (!ready_strip && t < 200) begin
         t++;
         @(negedge clk);
      end
      chk("desc_timeout", 64'(t < 200), 64'd1);
      @(posedge clk);
      #1;
      valid_strip = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] kp, input logic l);
      int t = 0;
      valid_in = 1'b1;
      data_in = d;
      keep_in = kp;
      last_in = l;
      @(negedge clk);
      while (!ready_in && t < 200) begin
         t++;
         @(negedge clk);
      end
      chk("beat_timeout", 64'(t < 200), 64'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   initial begin
      valid_in = 1'b0;
      data_in = '0;
      keep_in = '0;
      last_in = 1'b0;
      ready_out = 1'b1;
      ready_header = 1'b1;
      valid_strip = 1'b0;
      byte_strip_cnt = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_valid_header", 64'(valid_header), 64'd0);
      chk("rst_data_out", 64'(data_out), 64'd0);
      chk("rst_keep_out", 64'(keep_out), 64'd0);
      chk("rst_last_out", 64'(last_out), 64'd0);
      chk("rst_ready_strip", 64'(ready_strip), 64'd1);
      chk("rst_ready_in", 64'(ready_in), 64'd0);
      rst_n = 1'b1;
      // N=2, tail fits in the last beat
      send_desc(2'd1);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      send_beat(32'h11223344, 4'b1111, 1'b0);
      send_beat(32'h55669999, 4'b1100, 1'b1);
      idle(4);
      exp_hdr("t1_hdr", {4'b0011, 32'h0000AABB}, '1);
      exp_out("t1_o0", {1'b0, 4'b1111, 32'hCCDD1122});
      exp_out("t1_o1", {1'b1, 4'b1111, 32'h33445566});
      exp_empty("t1");
      // N=1, tail spills into a flush beat
      send_desc(2'd0);
      send_beat(32'h10203040, 4'b1111, 1'b0);
      send_beat(32'h50607099, 4'b1110, 1'b1);
      @(negedge clk);
      chk("t2_flush_ready_in", 64'(ready_in), 64'd0);
      idle(4);
      exp_hdr("t2_hdr", {4'b0001, 32'h00000010}, '1);
      exp_out("t2_o0", {1'b0, 4'b1111, 32'h20304050});
      exp_out("t2_o1", {1'b1, 4'b1100, 32'h60700000});
      exp_empty("t2");
      // N=4, payload passes through unchanged
      send_desc(2'd3);
      send_beat(32'h01020304, 4'b1111, 1'b0);
      send_beat(32'h05060708, 4'b1111, 1'b0);
      send_beat(32'h090A0BCC, 4'b1110, 1'b1);
      idle(4);
      exp_hdr("t3_hdr", {4'b1111, 32'h01020304}, '1);
      exp_out("t3_o0", {1'b0, 4'b1111, 32'h05060708});
      exp_out("t3_o1", {1'b1, 4'b1110, 32'h090A0B00});
      exp_empty("t3");
      // single-beat packets, N=2
      send_desc(2'd1);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b1);
      idle(4);
      exp_hdr("t4a_hdr", {4'b0011, 32'h0000AABB}, '1);
      exp_out("t4a_o0", {1'b1, 4'b1100, 32'hCCDD0000});
      exp_empty("t4a");
      send_desc(2'd1);
      send_beat(32'hAABBCCDD, 4'b1100, 1'b1);
      idle(4);
      exp_hdr("t4b_hdr", {4'b0011, 32'h0000AABB}, '1);
      exp_empty("t4b");
      err_cnt = 0;
      send_desc(2'd1);
      send_beat(32'hAABBCCDD, 4'b1000, 1'b1);
      idle(4);
      exp_hdr("t4c_hdr_keep", {4'b0010, 32'h0}, {4'hF, 32'h0});
      exp_empty("t4c");
`ifdef STRIP_HDR_ERR_EN
      chk("t4c_err_short", 64'(err_cnt), 64'd1);
`endif
      // payload backpressure mid-packet
      send_desc(2'd1);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      send_beat(32'h11223344, 4'b1111, 1'b0);
      ready_out = 1'b0;
      fork
         send_beat(32'h55669999, 4'b1100, 1'b1);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("t5_hold_data", 64'(data_out), 64'h00000000CCDD1122);
               chk("t5_hold_ready_in", 64'(ready_in), 64'd0);
            end
            @(posedge clk);
            #1;
            ready_out = 1'b1;
         end
      join
      idle(4);
      exp_hdr("t5_hdr", {4'b0011, 32'h0000AABB}, '1);
      exp_out("t5_o0", {1'b0, 4'b1111, 32'hCCDD1122});
      exp_out("t5_o1", {1'b1, 4'b1111, 32'h33445566});
      exp_empty("t5");
      // undrained header stalls the next packet's first beat
      ready_header = 1'b0;
      send_desc(2'd1);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b1);
      send_desc(2'd0);
      fork
         send_beat(32'h12345678, 4'b1111, 1'b1);
         begin
            repeat (4) begin
               @(negedge clk);
               chk("t6_ready_in", 64'(ready_in), 64'd0);
            end
            @(posedge clk);
            #1;
            ready_header = 1'b1;
         end
      join
      idle(4);
      exp_hdr("t6_hdr0", {4'b0011, 32'h0000AABB}, '1);
      exp_hdr("t6_hdr1", {4'b0001, 32'h00000012}, '1);
      exp_out("t6_o0", {1'b1, 4'b1100, 32'hCCDD0000});
      exp_out("t6_o1", {1'b1, 4'b1110, 32'h34567800});
      exp_empty("t6");
      // reset mid-packet, then a clean packet
      ready_header = 1'b0;
      send_desc(2'd1);
      send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
      send_beat(32'h11223344, 4'b1111, 1'b0);
      ready_out = 1'b0;
      @(negedge clk);
      chk("t7_pre_valid_out", 64'(valid_out), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t7_valid_out", 64'(valid_out), 64'd0);
      chk("t7_valid_header", 64'(valid_header), 64'd0);
      chk("t7_ready_strip", 64'(ready_strip), 64'd1);
      chk("t7_ready_in", 64'(ready_in), 64'd0);
      rst_n = 1'b1;
      ready_out = 1'b1;
      ready_header = 1'b1;
      out_q.delete();
      hdr_q.delete();
      send_desc(2'd0);
      send_beat(32'h10203040, 4'b1111, 1'b0);
      send_beat(32'h50607099, 4'b1110, 1'b1);
      idle(4);
      exp_hdr("t7_hdr", {4'b0001, 32'h00000010}, '1);
      exp_out("t7_o0", {1'b0, 4'b1111, 32'h20304050});
      exp_out("t7_o1", {1'b1, 4'b1100, 32'h60700000});
      exp_empty("t7");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
